// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller.
//  - ALU_CTRL_* : 4-bit operation codes presented on alu_ctrl
//  - OP_*       : 2-bit slice result-select codes (ctrl[1:0])
//  - state_t    : controller FSM states
//  - decode_ctrl: splits a ctrl code into {ainvert, binvert, op, legal}
package alu_pkg;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] op;
        logic       legal;
    } ctrl_dec_t;

    function automatic ctrl_dec_t decode_ctrl(input logic [3:0] ctrl);
        ctrl_dec_t d;
        d.ainvert = ctrl[3];
        d.binvert = ctrl[2];
        d.op      = ctrl[1:0];
        case (ctrl)
            ALU_CTRL_AND, ALU_CTRL_OR, ALU_CTRL_ADD,
            ALU_CTRL_SUB, ALU_CTRL_SLT, ALU_CTRL_NOR: d.legal = 1'b1;
            default:                                  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice (combinational).
//  a, b      : operand bits
//  less      : value presented on result when op selects LESS
//  ainvert   : invert a before use
//  binvert   : invert b before use
//  c_in      : raw carry in (no internal override; the caller owns the carry)
//  op        : result select (AND / OR / ADD / LESS)
//  result    : selected slice output
//  c_out     : full-adder carry out
//  sum       : full-adder sum, available regardless of op
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       c_in,
    input  logic [1:0] op,
    output logic       result,
    output logic       c_out,
    output logic       sum
);

    logic a_eff;
    logic b_eff;

    always_comb begin
        a_eff  = a ^ ainvert;
        b_eff  = b ^ binvert;
        sum    = a_eff ^ b_eff ^ c_in;
        c_out  = (a_eff & b_eff) | (a_eff & c_in) | (b_eff & c_in);
        result = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = sum;
            OP_LESS: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one alu_bit_slice LSB-first for WIDTH cycles.
//  clk, rst   : clock (rising edge), synchronous active-high reset
//  in_valid   : operation request; in_ready high only in IDLE
//  a, b       : WIDTH-bit operands, captured on accept
//  alu_ctrl   : operation code (AND/OR/ADD/SUB/SLT/NOR), captured on accept
//  out_valid  : result available (DONE), held until out_ready
//  result     : WIDTH-bit result
//  zero       : result == 0, valid in DONE
//  overflow   : signed overflow for ADD/SUB, else 0
//  err        : captured alu_ctrl was not a legal code
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    ctrl_dec_t        dec_q;
    logic [CNT_W-1:0] idx;
    logic             carry;
    logic             sum_msb;
    logic             msb_ovf;
    logic             last_bit;

    logic             slice_result;
    logic             slice_c_out;
    logic             slice_sum;

    // Carry register is preloaded with binvert on accept, so bit 0 sees binvert
    // as its carry-in and every later bit sees the previous bit's carry-out.
    alu_bit_slice u_slice (
        .a       (a_reg[idx]),
        .b       (b_reg[idx]),
        .less    (1'b0),
        .ainvert (dec_q.ainvert),
        .binvert (dec_q.binvert),
        .c_in    (carry),
        .op      (dec_q.op),
        .result  (slice_result),
        .c_out   (slice_c_out),
        .sum     (slice_sum)
    );

    assign last_bit = (idx == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = (dec_q.legal && dec_q.op == OP_LESS) ? FIX : DONE;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            dec_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
            sum_msb  <= 1'b0;
            msb_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        dec_q    <= decode_ctrl(alu_ctrl);
                        carry    <= decode_ctrl(alu_ctrl).binvert;
                        idx      <= '0;
                        result   <= '0;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                RUN: begin
                    result[idx] <= dec_q.legal ? slice_result : 1'b0;
                    carry       <= slice_c_out;
                    if (last_bit) begin
                        overflow <= dec_q.legal && (dec_q.op == OP_ADD) && (carry ^ slice_c_out);
                        sum_msb  <= slice_sum;
                        msb_ovf  <= carry ^ slice_c_out;
                        err      <= ~dec_q.legal;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                FIX: begin
                    // Signed less-than: MSB of a-b corrected by the overflow flag.
                    result[0] <= sum_msb ^ msb_ovf;
                end
                default: ;
            endcase
        end
    end

    assign zero = (state == DONE) && (result == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   ctrl;
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         er;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         er;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        check("ready_before_issue", 32'(in_ready), 32'd1);
        a        = v.a;
        b        = v.b;
        alu_ctrl = v.ctrl;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sb.push_back('{res: v.res, z: v.z, ov: v.ov, er: v.er});
        check("busy_in_ready", 32'(in_ready), 32'd0);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic await_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) begin
            bad++;
            total++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got output expected none queued");
            return;
        end
        e = sb.pop_front();
        check("result",   32'(result),   32'(e.res));
        check("zero",     32'(zero),     32'(e.z));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("err",      32'(err),      32'(e.er));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_in_ready",  32'(in_ready),  32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   n;
        vec_t v;

        //           a      b      ctrl     res    z     ov    er    lat
        vecs[0]  = '{8'h7F, 8'h01, 4'b0010, 8'h80, 1'b0, 1'b1, 1'b0, 9};
        vecs[1]  = '{8'h05, 8'h05, 4'b0110, 8'h00, 1'b1, 1'b0, 1'b0, 9};
        vecs[2]  = '{8'h80, 8'h01, 4'b0110, 8'h7F, 1'b0, 1'b1, 1'b0, 9};
        vecs[3]  = '{8'h80, 8'h01, 4'b0111, 8'h01, 1'b0, 1'b0, 1'b0, 10};
        vecs[4]  = '{8'h01, 8'h80, 4'b0111, 8'h00, 1'b1, 1'b0, 1'b0, 10};
        vecs[5]  = '{8'h7F, 8'h80, 4'b0111, 8'h00, 1'b1, 1'b0, 1'b0, 10};
        vecs[6]  = '{8'hF0, 8'h3C, 4'b0000, 8'h30, 1'b0, 1'b0, 1'b0, 9};
        vecs[7]  = '{8'hF0, 8'h3C, 4'b0001, 8'hFC, 1'b0, 1'b0, 1'b0, 9};
        vecs[8]  = '{8'h0F, 8'hF0, 4'b1100, 8'h00, 1'b1, 1'b0, 1'b0, 9};
        vecs[9]  = '{8'hA5, 8'h5A, 4'b0101, 8'h00, 1'b1, 1'b0, 1'b1, 9};
        vecs[10] = '{8'hFF, 8'h01, 4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 9};
        vecs[11] = '{8'h01, 8'h02, 4'b0110, 8'hFF, 1'b0, 1'b0, 1'b0, 9};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_ctrl  = '0;
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            await_done(n);
            check("latency", 32'(n + 1), 32'(vecs[i].lat));
            check_result();
            release_out();
        end

        // Backpressure: hold DONE for 5 cycles with a stray request present.
        issue(vecs[0]);
        await_done(n);
        for (int k = 0; k < 5; k++) begin
            a        = 8'h11;
            b        = 8'h22;
            alu_ctrl = 4'b0010;
            in_valid = 1'b1;
            step();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_result",    32'(result),    32'h80);
            check("hold_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        check_result();
        release_out();
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_stray_out", 32'(out_valid), 32'd0);
        end

        // Reset while RUN is at bit index 3.
        a        = 8'h7F;
        b        = 8'h01;
        alu_ctrl = 4'b0010;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            check("abort_no_out", 32'(out_valid), 32'd0);
        end

        v = '{8'h01, 8'h01, 4'b0010, 8'h02, 1'b0, 1'b0, 1'b0, 9};
        issue(v);
        await_done(n);
        check("post_rst_latency", 32'(n + 1), 32'd9);
        check_result();
        release_out();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
